// File: rtl/fft_stage_seq.sv
// One radix-2 DIT stage: buffers a frame, issues butterfly operand pairs with
// twiddle addresses, gathers results in place and streams them out in natural order.
module fft_stage_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int N_LOG2     = 4,
  parameter int STAGE_W    = 3
) (
  input  logic                  clk_data,
  input  logic                  rst,
  input  logic [STAGE_W-1:0]    stage,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_real,
  input  logic [DATA_WIDTH-1:0] in_imag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_real,
  output logic [DATA_WIDTH-1:0] out_imag,
  output logic                  out_last,
  output logic                  bf_en,
  output logic [DATA_WIDTH-1:0] bf_xp_real,
  output logic [DATA_WIDTH-1:0] bf_xp_imag,
  output logic [DATA_WIDTH-1:0] bf_xq_real,
  output logic [DATA_WIDTH-1:0] bf_xq_imag,
  output logic [N_LOG2-2:0]     tw_addr,
  input  logic                  bf_valid,
  input  logic [DATA_WIDTH-1:0] bf_yp_real,
  input  logic [DATA_WIDTH-1:0] bf_yp_imag,
  input  logic [DATA_WIDTH-1:0] bf_yq_real,
  input  logic [DATA_WIDTH-1:0] bf_yq_imag
);
  localparam int N    = 1 << N_LOG2;
  localparam int HALF = N / 2;
  localparam int AW   = N_LOG2;

  typedef enum logic [1:0] {LOAD, ISSUE, DRAIN, UNLOAD} state_t;

  state_t              state;
  logic [AW-1:0]       wcnt;
  logic [AW-1:0]       rd;
  logic [AW-2:0]       j;
  logic [AW-1:0]       r;
  logic [STAGE_W-1:0]  s_q;

  logic [DATA_WIDTH-1:0] in_re [N];
  logic [DATA_WIDTH-1:0] in_im [N];
  logic [DATA_WIDTH-1:0] ob_re [N];
  logic [DATA_WIDTH-1:0] ob_im [N];

  logic [AW-1:0]       iss_p, iss_q, cap_p, cap_q;
  logic [AW-2:0]       iss_tw;
  logic [STAGE_W-1:0]  s_next;
  logic                load_beat, cap_en;

  // Lower index of butterfly pair idx in a stage of span 2^s.
  function automatic logic [AW-1:0] low_index(input logic [AW-2:0] idx,
                                              input logic [STAGE_W-1:0] s);
    int si;
    int ji;
    si = int'(s);
    ji = int'(idx);
    return AW'(((ji >> si) << (si + 1)) + (ji & ((1 << si) - 1)));
  endfunction

  function automatic logic [AW-1:0] high_index(input logic [AW-2:0] idx,
                                               input logic [STAGE_W-1:0] s);
    return AW'(int'(low_index(idx, s)) + (1 << int'(s)));
  endfunction

  function automatic logic [AW-2:0] tw_index(input logic [AW-2:0] idx,
                                             input logic [STAGE_W-1:0] s);
    int si;
    int ji;
    si = int'(s);
    ji = int'(idx);
    return (AW-1)'((ji & ((1 << si) - 1)) << (N_LOG2 - 1 - si));
  endfunction

  always_comb begin
    iss_p     = low_index(j, s_q);
    iss_q     = high_index(j, s_q);
    iss_tw    = tw_index(j, s_q);
    cap_p     = low_index(r[AW-2:0], s_q);
    cap_q     = high_index(r[AW-2:0], s_q);
    s_next    = (int'(stage) >= N_LOG2) ? STAGE_W'(N_LOG2 - 1) : stage;
    load_beat = (state == LOAD) && in_valid;
    cap_en    = ((state == ISSUE) || (state == DRAIN)) && bf_valid && (r != AW'(HALF));
  end

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == UNLOAD);
  assign out_last  = (state == UNLOAD) && (rd == AW'(N - 1));
  assign out_real  = (state == UNLOAD) ? ob_re[rd] : '0;
  assign out_imag  = (state == UNLOAD) ? ob_im[rd] : '0;

  // Buffer storage carries no reset; its contents after reset are don't-care.
  always_ff @(posedge clk_data) begin
    if (!rst && load_beat) begin
      in_re[wcnt] <= in_real;
      in_im[wcnt] <= in_imag;
    end
    if (!rst && cap_en) begin
      ob_re[cap_p] <= bf_yp_real;
      ob_im[cap_p] <= bf_yp_imag;
      ob_re[cap_q] <= bf_yq_real;
      ob_im[cap_q] <= bf_yq_imag;
    end
  end

  always_ff @(posedge clk_data) begin
    if (rst) begin
      state      <= LOAD;
      wcnt       <= '0;
      rd         <= '0;
      j          <= '0;
      r          <= '0;
      s_q        <= '0;
      bf_en      <= 1'b0;
      tw_addr    <= '0;
      bf_xp_real <= '0;
      bf_xp_imag <= '0;
      bf_xq_real <= '0;
      bf_xq_imag <= '0;
    end else begin
      bf_en <= 1'b0;
      if (cap_en) r <= r + 1'b1;
      case (state)
        LOAD: begin
          if (in_valid) begin
            if (wcnt == '0) s_q <= s_next;
            wcnt <= wcnt + 1'b1;
            if (wcnt == AW'(N - 1)) begin
              state <= ISSUE;
              j     <= '0;
            end
          end
        end
        ISSUE: begin
          // Operands and ROM address leave together; the ROM's own register
          // delays the factor by one cycle, which the butterfly expects.
          bf_en      <= 1'b1;
          tw_addr    <= iss_tw;
          bf_xp_real <= in_re[iss_p];
          bf_xp_imag <= in_im[iss_p];
          bf_xq_real <= in_re[iss_q];
          bf_xq_imag <= in_im[iss_q];
          j          <= j + 1'b1;
          if (j == (AW-1)'(HALF - 1)) state <= DRAIN;
        end
        DRAIN: begin
          if ((r == AW'(HALF)) || (cap_en && (r == AW'(HALF - 1)))) state <= UNLOAD;
        end
        UNLOAD: begin
          if (out_ready) begin
            rd <= rd + 1'b1;
            if (rd == AW'(N - 1)) begin
              state <= LOAD;
              r     <= '0;
              wcnt  <= '0;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_stage_seq.sv
// Bench for fft_stage_seq: external butterfly + registered twiddle ROM model,
// frame-level reference model, and directed frame sequence with random data.
module tb_fft_stage_seq;
  localparam int DW   = 16;
  localparam int NL   = 4;
  localparam int SW   = 3;
  localparam int N    = 16;
  localparam int HALF = 8;
  localparam int LAT  = 12;

  localparam logic signed [DW-1:0] ROM_RE [8] = '{16'sd8192, 16'sd7568, 16'sd5793, 16'sd3135,
                                                  16'sd0, -16'sd3135, -16'sd5793, -16'sd7568};
  localparam logic signed [DW-1:0] ROM_IM [8] = '{16'sd0, -16'sd3135, -16'sd5793, -16'sd7568,
                                                  -16'sd8192, -16'sd7568, -16'sd5793, -16'sd3135};

  logic          clk_data = 1'b0;
  logic          rst;
  logic [SW-1:0] stage;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_real, in_imag;
  logic          out_valid, out_ready, out_last;
  logic [DW-1:0] out_real, out_imag;
  logic          bf_en;
  logic [DW-1:0] bf_xp_real, bf_xp_imag, bf_xq_real, bf_xq_imag;
  logic [NL-2:0] tw_addr;
  logic          bf_valid = 1'b0;
  logic [DW-1:0] bf_yp_real, bf_yp_imag, bf_yq_real, bf_yq_imag;

  always #5 clk_data = ~clk_data;

  fft_stage_seq #(.DATA_WIDTH(DW), .N_LOG2(NL), .STAGE_W(SW)) dut (
    .clk_data(clk_data), .rst(rst), .stage(stage),
    .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
    .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
    .out_last(out_last), .bf_en(bf_en),
    .bf_xp_real(bf_xp_real), .bf_xp_imag(bf_xp_imag),
    .bf_xq_real(bf_xq_real), .bf_xq_imag(bf_xq_imag), .tw_addr(tw_addr),
    .bf_valid(bf_valid), .bf_yp_real(bf_yp_real), .bf_yp_imag(bf_yp_imag),
    .bf_yq_real(bf_yq_real), .bf_yq_imag(bf_yq_imag)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Butterfly definition: yp = a + W*b, yq = a - W*b, W in Q13.
  task automatic bfly(input logic [DW-1:0] ar, ai, br, bi, input logic [NL-2:0] k,
                      output logic [DW-1:0] pr, pi, qr, qi);
    int wr, wi, tr, ti;
    wr = int'(ROM_RE[k]);
    wi = int'(ROM_IM[k]);
    tr = (wr * int'($signed(br)) - wi * int'($signed(bi))) >>> 13;
    ti = (wr * int'($signed(bi)) + wi * int'($signed(br))) >>> 13;
    pr = DW'(int'($signed(ar)) + tr);
    pi = DW'(int'($signed(ai)) + ti);
    qr = DW'(int'($signed(ar)) - tr);
    qi = DW'(int'($signed(ai)) - ti);
  endtask

  // External pipelined butterfly with a registered twiddle ROM.
  typedef struct {
    logic [DW-1:0] pr, pi, qr, qi;
    int            due;
  } res_t;
  res_t          res_q[$];
  res_t          nr, er;
  int            cyc = 0;
  int            cap_cnt = 0;
  int            gap_mode = 0;
  int            gap_left = 0;
  logic          en_d = 1'b0;
  logic [NL-2:0] k_q;
  logic [DW-1:0] dpr, dpi, dqr, dqi;

  always @(posedge clk_data) begin
    cyc++;
    if (bf_valid) cap_cnt++;
    if (rst) begin
      res_q.delete();
      en_d <= 1'b0;
    end else begin
      if (en_d) begin
        bfly(dpr, dpi, dqr, dqi, k_q, nr.pr, nr.pi, nr.qr, nr.qi);
        nr.due = cyc + LAT - 2;
        res_q.push_back(nr);
      end
      en_d <= bf_en;
      k_q  <= tw_addr;
      dpr  <= bf_xp_real;
      dpi  <= bf_xp_imag;
      dqr  <= bf_xq_real;
      dqi  <= bf_xq_imag;
    end
  end

  always @(negedge clk_data) begin
    bf_valid = 1'b0;
    if (gap_left > 0) begin
      gap_left--;
    end else if (res_q.size() > 0 && res_q[0].due <= cyc) begin
      er = res_q.pop_front();
      bf_valid   = 1'b1;
      bf_yp_real = er.pr;
      bf_yp_imag = er.pi;
      bf_yq_real = er.qr;
      bf_yq_imag = er.qi;
      gap_left   = (gap_mode != 0) ? int'($urandom_range(0, 5)) : 0;
    end
  end

  // Frame-level reference: walk the blocks of size 2*span, pair every element
  // with its partner one span up, twiddle exponent steps by N/(2*span).
  logic [DW-1:0]   fr_re [N];
  logic [DW-1:0]   fr_im [N];
  logic [2*DW-1:0] exp_q[$];
  logic [NL-2:0]   tw_q[$];
  logic [4*DW-1:0] op_q[$];

  task automatic build_expect(input int s);
    int se, span, p, q;
    logic [DW-1:0] rr [N];
    logic [DW-1:0] ri [N];
    logic [NL-2:0] k;
    se   = (s >= NL) ? NL - 1 : s;
    span = 1 << se;
    exp_q.delete();
    tw_q.delete();
    op_q.delete();
    for (int blk = 0; blk < N; blk += 2 * span) begin
      for (int pos = 0; pos < span; pos++) begin
        p = blk + pos;
        q = p + span;
        k = (NL-1)'(pos * (HALF / span));
        tw_q.push_back(k);
        op_q.push_back({fr_re[p], fr_im[p], fr_re[q], fr_im[q]});
        bfly(fr_re[p], fr_im[p], fr_re[q], fr_im[q], k, rr[p], ri[p], rr[q], ri[q]);
      end
    end
    for (int i = 0; i < N; i++) exp_q.push_back({rr[i], ri[i]});
  endtask

  task automatic load_frame(input int s, input bit ramp);
    int k, guard;
    for (int i = 0; i < N; i++) begin
      fr_re[i] = ramp ? DW'(i) : DW'($urandom);
      fr_im[i] = ramp ? '0 : DW'($urandom);
    end
    build_expect(s);
    k = 0;
    guard = 0;
    while (k < N && guard < 200) begin
      @(negedge clk_data);
      chk("in_ready_load", 64'(in_ready), 64'(1));
      in_valid = ($urandom_range(0, 3) != 0);
      stage    = (k == 0) ? SW'(s) : SW'($urandom);
      in_real  = fr_re[k];
      in_imag  = fr_im[k];
      @(posedge clk_data);
      if (in_valid) k++;
      guard++;
    end
    chk("load_beats", 64'(k), 64'(N));
  endtask

  task automatic unload_frame(input int rdy_mode);
    int issued, outs, en_runs, cap_base, ucyc;
    bit prev_en, stalled, seen_out;
    logic [2*DW-1:0] held;
    issued = 0; outs = 0; en_runs = 0; ucyc = 0;
    prev_en = 0; stalled = 0; seen_out = 0;
    held = '0;
    cap_base = cap_cnt;
    for (int c = 0; c < 600 && outs < N; c++) begin
      @(negedge clk_data);
      in_valid = 1'b0;
      chk("in_ready_busy", 64'(in_ready), 64'(0));
      if (bf_en) begin
        if (!prev_en) en_runs++;
        if (tw_q.size() > 0) begin
          chk("tw_addr", 64'(tw_addr), 64'(tw_q.pop_front()));
          chk("operands", {bf_xp_real, bf_xp_imag, bf_xq_real, bf_xq_imag}, op_q.pop_front());
        end else begin
          chk("extra_bf_en", 64'(bf_en), 64'(0));
        end
        issued++;
      end
      prev_en = bf_en;
      if (stalled) chk("stall_hold", 64'({out_valid, out_real, out_imag}), 64'({1'b1, held}));
      if (out_valid && !seen_out) begin
        seen_out = 1;
        chk("captures_before_unload", 64'(cap_cnt - cap_base), 64'(HALF));
      end
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((ucyc % 4) == 0) || ((ucyc % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid) begin
        ucyc++;
        chk("out_data", 64'({out_real, out_imag}), 64'(exp_q[0]));
        chk("out_last", 64'(out_last), 64'(outs == N - 1));
        if (out_ready) begin
          void'(exp_q.pop_front());
          outs++;
        end
        stalled = !out_ready;
        held    = {out_real, out_imag};
      end else begin
        stalled = 0;
      end
    end
    chk("frame_outputs", 64'(outs), 64'(N));
    chk("pairs_issued", 64'(issued), 64'(HALF));
    chk("bf_en_bursts", 64'(en_runs), 64'(1));
    @(negedge clk_data);
    out_ready = 1'b0;
    chk("back_to_load", 64'({in_ready, out_valid, out_last, bf_en}), 64'(4'b1000));
  endtask

  task automatic run_frame(input int s, input bit ramp, input int gaps, input int rdy_mode);
    gap_mode = gaps;
    load_frame(s, ramp);
    unload_frame(rdy_mode);
  endtask

  initial begin
    int seen, g;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    stage = '0;
    in_real = '0;
    in_imag = '0;
    repeat (3) @(posedge clk_data);
    @(negedge clk_data);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_bf_en", 64'(bf_en), 64'(0));
    chk("rst_tw_addr", 64'(tw_addr), 64'(0));
    chk("rst_bf_x", {bf_xp_real, bf_xp_imag, bf_xq_real, bf_xq_imag}, 64'(0));
    chk("rst_out_data", 64'({out_real, out_imag}), 64'(0));
    rst = 1'b0;

    run_frame(0, 1'b1, 0, 0);
    run_frame(3, 1'b0, 0, 0);
    run_frame(1, 1'b0, 1, 0);
    run_frame(7, 1'b0, 0, 1);
    run_frame(2, 1'b0, 1, 2);

    // Reset while the fourth pair (j=3) is being issued; the partial frame is dropped.
    gap_mode = 0;
    load_frame(2, 1'b0);
    seen = 0;
    g = 0;
    while (seen < 3 && g < 50) begin
      @(negedge clk_data);
      in_valid = 1'b0;
      if (bf_en) seen++;
      g++;
    end
    chk("reached_issue", 64'(seen), 64'(3));
    rst = 1'b1;
    @(negedge clk_data);
    chk("midrst_bf_en", 64'(bf_en), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_tw_addr", 64'(tw_addr), 64'(0));
    chk("midrst_bf_x", {bf_xp_real, bf_xp_imag, bf_xq_real, bf_xq_imag}, 64'(0));
    rst = 1'b0;

    run_frame(0, 1'b0, 0, 0);
    run_frame(1, 1'b0, 1, 1);
    run_frame(3, 1'b0, 0, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
